// File: rtl/compositor_pkg.sv
// Shared mode encoding and collision pair numbering for the layer compositor.
// Combinational helpers only; the package adds no latency and has no handshake.
package compositor_pkg;

    typedef enum logic [1:0] {
        MODE_PLAY    = 2'd0,
        MODE_TITLE   = 2'd1,
        MODE_BLANK   = 2'd2,
        MODE_BG_ONLY = 2'd3
    } mode_t;

    // Upper-triangle numbering of layer pairs (i<j), row by row
    function automatic int pair_index(input int i, input int j, input int layers);
        return i * layers - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/layer_compositor_if.sv
// Pixel-in / colour-out bundle between the sprite sources, compositor and VGA timing.
// Wires only: no latency and no backpressure, because the pixel stream never stalls.
interface layer_compositor_if #(
    parameter int LAYERS = 6,
    parameter int CW     = 12,
    parameter int NPAIR  = LAYERS * (LAYERS - 1) / 2
);
    import compositor_pkg::*;

    localparam int HW = $clog2(LAYERS + 1);

    logic                 pix_valid;
    logic                 frame_start;
    mode_t                mode;
    logic [LAYERS-1:0]    layer_mask;
    logic [LAYERS-1:0]    layer_en;
    logic [LAYERS*CW-1:0] layer_rgb;
    logic [CW-1:0]        bg_rgb;
    logic [CW-1:0]        title_rgb;

    logic [CW-1:0]        rgb_out;
    logic                 rgb_valid;
    logic [HW-1:0]        hit_layer;
    logic [NPAIR-1:0]     coll_flags;
    logic                 coll_valid;

    modport master (
        output pix_valid, frame_start, mode, layer_mask, layer_en,
               layer_rgb, bg_rgb, title_rgb,
        input  rgb_out, rgb_valid, hit_layer, coll_flags, coll_valid
    );

    modport slave (
        input  pix_valid, frame_start, mode, layer_mask, layer_en,
               layer_rgb, bg_rgb, title_rgb,
        output rgb_out, rgb_valid, hit_layer, coll_flags, coll_valid
    );

endinterface

// File: rtl/pair_collision_acc.sv
// Per-frame OR of pairwise layer overlaps, published on the frame_start pixel.
// Lives at pipeline stage 2, so flags move 2 cycles after frame_start; no backpressure.
module pair_collision_acc
    import compositor_pkg::*;
#(
    parameter int LAYERS = 6,
    parameter int NPAIR  = LAYERS * (LAYERS - 1) / 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LAYERS-1:0] opaque,
    input  logic              valid,
    input  logic              play,
    input  logic              frame_start,
    output logic [NPAIR-1:0]  coll_flags,
    output logic              coll_valid
);

    localparam int PW = (NPAIR > 1) ? $clog2(NPAIR) : 1;

    logic [NPAIR-1:0] acc;
    logic [NPAIR-1:0] pairs;

    always_comb begin
        pairs = '0;
        if (valid && play) begin
            for (int i = 0; i < LAYERS; i++) begin
                for (int j = i + 1; j < LAYERS; j++) begin
                    pairs[PW'(pair_index(i, j, LAYERS))] = opaque[i] & opaque[j];
                end
            end
        end
    end

    // The frame_start pixel seeds the new frame instead of joining the old one
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc        <= '0;
            coll_flags <= '0;
            coll_valid <= 1'b0;
        end else if (frame_start) begin
            coll_flags <= acc;
            coll_valid <= 1'b1;
            acc        <= pairs;
        end else begin
            coll_valid <= 1'b0;
            acc        <= acc | pairs;
        end
    end

endmodule

// File: rtl/layer_compositor.sv
// N-layer priority compositor with colour-key transparency; 2-cycle latency, 1 pixel/clk, no stalls.
// Collision accumulation is built only when LAYER_COMPOSITOR_COLLISION_EN is defined.
module layer_compositor
    import compositor_pkg::*;
#(
    parameter int          LAYERS = 6,
    parameter int          CW     = 12,
    parameter logic [CW-1:0] KEY  = '0,
    parameter int          NPAIR  = LAYERS * (LAYERS - 1) / 2
) (
    input  logic clk,
    input  logic rst,
    layer_compositor_if.slave bus
);

    localparam int            HW   = $clog2(LAYERS + 1);
    localparam logic [HW-1:0] NONE = HW'(LAYERS);

    logic [LAYERS-1:0]    opaque_in;

    logic [LAYERS-1:0]    s1_opaque;
    logic [LAYERS*CW-1:0] s1_layer_rgb;
    logic [CW-1:0]        s1_bg;
    logic [CW-1:0]        s1_title;
    mode_t                s1_mode;
    logic                 s1_valid;

    logic [CW-1:0]        sel_rgb;
    logic [HW-1:0]        sel_hit;

    logic [CW-1:0]        rgb_q;
    logic                 valid_q;
    logic [HW-1:0]        hit_q;

    always_comb begin
        opaque_in = '0;
        for (int i = 0; i < LAYERS; i++) begin
            opaque_in[i] = bus.layer_en[i] & bus.layer_mask[i]
                         & (bus.layer_rgb[i*CW +: CW] != KEY);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_opaque    <= '0;
            s1_layer_rgb <= '0;
            s1_bg        <= '0;
            s1_title     <= '0;
            s1_mode      <= MODE_PLAY;
            s1_valid     <= 1'b0;
        end else begin
            s1_opaque    <= opaque_in;
            s1_layer_rgb <= bus.layer_rgb;
            s1_bg        <= bus.bg_rgb;
            s1_title     <= bus.title_rgb;
            s1_mode      <= bus.mode;
            s1_valid     <= bus.pix_valid;
        end
    end

    // Scan from the lowest priority upward so the last hit is layer with smallest index
    always_comb begin
        sel_rgb = '0;
        sel_hit = NONE;
        if (s1_valid) begin
            case (s1_mode)
                MODE_PLAY: begin
                    sel_rgb = s1_bg;
                    for (int i = LAYERS - 1; i >= 0; i--) begin
                        if (s1_opaque[i]) begin
                            sel_rgb = s1_layer_rgb[i*CW +: CW];
                            sel_hit = HW'(i);
                        end
                    end
                end
                MODE_TITLE:   sel_rgb = s1_title;
                MODE_BG_ONLY: sel_rgb = s1_bg;
                default:      sel_rgb = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb_q   <= '0;
            valid_q <= 1'b0;
            hit_q   <= NONE;
        end else begin
            rgb_q   <= sel_rgb;
            valid_q <= s1_valid;
            hit_q   <= sel_hit;
        end
    end

    assign bus.rgb_out   = rgb_q;
    assign bus.rgb_valid = valid_q;
    assign bus.hit_layer = hit_q;

`ifdef LAYER_COMPOSITOR_COLLISION_EN
    logic s1_fs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_fs <= 1'b0;
        end else begin
            s1_fs <= bus.frame_start;
        end
    end

    pair_collision_acc #(
        .LAYERS (LAYERS),
        .NPAIR  (NPAIR)
    ) u_pair_collision_acc (
        .clk         (clk),
        .rst         (rst),
        .opaque      (s1_opaque),
        .valid       (s1_valid),
        .play        (s1_mode == MODE_PLAY),
        .frame_start (s1_fs),
        .coll_flags  (bus.coll_flags),
        .coll_valid  (bus.coll_valid)
    );
`else
    logic unused_fs;
    assign unused_fs      = bus.frame_start;
    assign bus.coll_flags = '0;
    assign bus.coll_valid = 1'b0;
`endif

endmodule

// File: tb/tb_layer_compositor.sv
// Randomised and directed bench for layer_compositor against a per-pixel reference model.
module tb_layer_compositor;
    import compositor_pkg::*;

    localparam int LAYERS = 6;
    localparam int CW     = 12;
    localparam int NPAIR  = LAYERS * (LAYERS - 1) / 2;
    localparam logic [CW-1:0] KEY = 12'h000;
`ifdef LAYER_COMPOSITOR_COLLISION_EN
    localparam bit COLL_EN = 1'b1;
`else
    localparam bit COLL_EN = 1'b0;
`endif

    typedef struct {
        bit           valid;
        bit           fs;
        mode_t        mode;
        logic [5:0]   mask;
        logic [5:0]   en;
        logic [71:0]  rgb;
        logic [11:0]  bg;
        logic [11:0]  title;
    } pix_t;

    typedef struct packed {
        logic [11:0] rgb;
        logic        valid;
        logic [2:0]  hit;
        logic [14:0] flags;
        logic        cv;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    layer_compositor_if #(.LAYERS(LAYERS), .CW(CW)) bus();

    layer_compositor #(.LAYERS(LAYERS), .CW(CW), .KEY(KEY)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_chk  = 0;
    int          n_pass = 0;
    out_t        exp_q[$];
    out_t        obs;
    out_t        exp_cur;
    bit          have_exp;
    logic [14:0] m_acc;
    logic [14:0] m_flags;

    // Reference: pixel colour from the priority rules, collision as a per-frame set of pairs
    task automatic model_step(input pix_t p, output out_t o);
        logic [11:0] c[LAYERS];
        bit          op[LAYERS];
        int          winner;
        logic [14:0] new_pairs;
        for (int i = 0; i < LAYERS; i++) begin
            c[i]  = p.rgb[i*CW +: CW];
            op[i] = p.en[i] && p.mask[i] && (c[i] != KEY);
        end
        o = '0;
        o.valid = p.valid;
        o.hit = 3'(LAYERS);
        if (p.valid) begin
            if (p.mode == MODE_PLAY) begin
                winner = LAYERS;
                for (int i = 0; i < LAYERS; i++) if (op[i] && winner == LAYERS) winner = i;
                o.rgb = (winner == LAYERS) ? p.bg : c[winner];
                o.hit = 3'(winner);
            end else if (p.mode == MODE_TITLE) o.rgb = p.title;
            else if (p.mode == MODE_BG_ONLY) o.rgb = p.bg;
        end
        new_pairs = '0;
        if (p.valid && p.mode == MODE_PLAY)
            for (int i = 0; i < LAYERS; i++)
                for (int j = i + 1; j < LAYERS; j++)
                    if (op[i] && op[j]) new_pairs[pair_index(i, j, LAYERS)] = 1'b1;
        if (p.fs) begin
            m_flags = m_acc;
            m_acc   = new_pairs;
            o.cv    = 1'b1;
        end else begin
            m_acc = m_acc | new_pairs;
        end
        o.flags = m_flags;
        if (!COLL_EN) begin
            o.flags = '0;
            o.cv    = 1'b0;
        end
    endtask

    function automatic pix_t idle_pix();
        pix_t p;
        p.valid = 1'b1; p.fs = 1'b0; p.mode = MODE_PLAY;
        p.mask = 6'h3F; p.en = 6'h00; p.rgb = '0;
        p.bg = 12'h555; p.title = 12'h0AA;
        return p;
    endfunction

    function automatic pix_t lay(input pix_t p, input int i, input logic [11:0] c);
        pix_t q = p;
        q.en[i] = 1'b1;
        q.rgb[i*CW +: CW] = c;
        return q;
    endfunction

    function automatic pix_t rand_pix();
        pix_t p;
        p.valid = ($urandom_range(0, 9) != 0);
        p.fs    = ($urandom_range(0, 29) == 0);
        p.mode  = ($urandom_range(0, 2) != 0) ? MODE_PLAY : mode_t'(2'($urandom_range(0, 3)));
        p.mask  = 6'($urandom);
        p.en    = 6'($urandom);
        for (int i = 0; i < LAYERS; i++)
            p.rgb[i*CW +: CW] = ($urandom_range(0, 3) == 0) ? KEY : 12'($urandom);
        p.bg    = 12'($urandom);
        p.title = 12'($urandom);
        return p;
    endfunction

    task automatic drive(input pix_t p);
        bus.pix_valid   = p.valid;
        bus.frame_start = p.fs;
        bus.mode        = p.mode;
        bus.layer_mask  = p.mask;
        bus.layer_en    = p.en;
        bus.layer_rgb   = p.rgb;
        bus.bg_rgb      = p.bg;
        bus.title_rgb   = p.title;
    endtask

    // One pixel per clock: sample the output due now, then present the next pixel
    task automatic step(input pix_t p);
        out_t o;
        @(negedge clk);
        have_exp = (exp_q.size() >= 2);
        if (have_exp) begin
            exp_cur = exp_q.pop_front();
            obs = {bus.rgb_out, bus.rgb_valid, bus.hit_layer, bus.coll_flags, bus.coll_valid};
        end
        drive(p);
        model_step(p, o);
        exp_q.push_back(o);
    endtask

    task automatic release_reset();
        pix_t off = idle_pix();
        off.valid = 1'b0;
        drive(off);
        exp_q.delete();
        m_acc = '0;
        m_flags = '0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        pix_t off = idle_pix();
        off.valid = 1'b0;
        drive(off);
        repeat (2) @(negedge clk);
        n_chk++; if (bus.rgb_out !== 12'h000) $display("FAIL reset_rgb: got %h want 000", bus.rgb_out); else n_pass++;
        n_chk++; if (bus.rgb_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.rgb_valid); else n_pass++;
        n_chk++; if (bus.hit_layer !== 3'd6) $display("FAIL reset_hit: got %0d want 6", bus.hit_layer); else n_pass++;
        n_chk++; if (bus.coll_flags !== 15'h0) $display("FAIL reset_flags: got %h want 0", bus.coll_flags); else n_pass++;
        n_chk++; if (bus.coll_valid !== 1'b0) $display("FAIL reset_cvalid: got %b want 0", bus.coll_valid); else n_pass++;
        release_reset();
    endtask

    // Directed sequence: stream-checked against the model, plus a constant check on one pixel
    task automatic run_seq(input string name, input pix_t seq[$], input int at,
                           input logic [11:0] w_rgb, input logic w_valid, input logic [2:0] w_hit);
        for (int k = 0; k < seq.size() + 2; k++) begin
            step((k < seq.size()) ? seq[k] : idle_pix());
            if (have_exp) begin
                n_chk++;
                if (obs !== exp_cur) $display("FAIL %s_stream: got %h want %h", name, obs, exp_cur);
                else n_pass++;
            end
            if (k == at + 2) begin
                n_chk++;
                if ({obs.rgb, obs.valid, obs.hit} !== {w_rgb, w_valid, w_hit})
                    $display("FAIL %s: got rgb=%h v=%b hit=%0d want rgb=%h v=%b hit=%0d",
                             name, obs.rgb, obs.valid, obs.hit, w_rgb, w_valid, w_hit);
                else n_pass++;
            end
        end
    endtask

    task automatic test_priority();
        pix_t s[$];
        pix_t p = lay(lay(idle_pix(), 1, 12'hF00), 3, 12'h0F0);
        s.push_back(p);
        run_seq("priority", s, 0, 12'hF00, 1'b1, 3'd1);
    endtask

    task automatic test_key_mask();
        pix_t s[$];
        pix_t p = lay(lay(idle_pix(), 0, 12'h000), 2, 12'h00F);
        p.mask[2] = 1'b0;
        s.push_back(p);
        run_seq("key_mask", s, 0, 12'h555, 1'b1, 3'd6);
    endtask

    task automatic test_modes();
        pix_t s[$];
        pix_t p = lay(lay(idle_pix(), 1, 12'hF00), 3, 12'h0F0);
        p.mode = MODE_TITLE;   s.push_back(p); run_seq("mode_title", s, 0, 12'h0AA, 1'b1, 3'd6);
        s.delete(); p.mode = MODE_BLANK;   s.push_back(p); run_seq("mode_blank", s, 0, 12'h000, 1'b1, 3'd6);
        s.delete(); p.mode = MODE_BG_ONLY; s.push_back(p); run_seq("mode_bg", s, 0, 12'h555, 1'b1, 3'd6);
        s.delete(); p.mode = MODE_PLAY; p.valid = 1'b0; s.push_back(p);
        run_seq("mode_invalid", s, 0, 12'h000, 1'b0, 3'd6);
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            step(rand_pix());
            if (have_exp) begin
                n_chk++;
                if (obs !== exp_cur) $display("FAIL random_k%0d: got %h want %h", k, obs, exp_cur);
                else n_pass++;
            end
        end
    endtask

    // Steps a frame sequence and checks the published vector at given frame_start slots
    task automatic run_frames(input string name, input pix_t seq[$],
                              input int at0, input logic [14:0] want0,
                              input int at1, input logic [14:0] want1);
        logic [14:0] w;
        for (int k = 0; k < seq.size() + 2; k++) begin
            step((k < seq.size()) ? seq[k] : idle_pix());
            if (have_exp) begin
                n_chk++;
                if (obs !== exp_cur) $display("FAIL %s_stream: got %h want %h", name, obs, exp_cur);
                else n_pass++;
            end
            if (k == at0 + 2 || k == at1 + 2) begin
                w = (k == at0 + 2) ? want0 : want1;
                if (!COLL_EN) w = '0;
                n_chk++;
                if (obs.flags !== w || obs.cv !== COLL_EN)
                    $display("FAIL %s_publish_k%0d: got flags=%h cv=%b want flags=%h cv=%b",
                             name, k, obs.flags, obs.cv, w, COLL_EN);
                else n_pass++;
            end
        end
    endtask

    task automatic test_collision();
        pix_t s[$];
        pix_t fs = idle_pix();
        pix_t ov = lay(lay(idle_pix(), 0, 12'h123), 4, 12'h456);
        fs.fs = 1'b1;
        s.push_back(fs);
        for (int k = 0; k < 3; k++) begin s.push_back(ov); s.push_back(idle_pix()); end
        s.push_back(fs);
        for (int k = 0; k < 8; k++) s.push_back(idle_pix());
        s.push_back(fs);
        run_frames("collision", s, 7, 15'h0008, 16, 15'h0000);
    endtask

    task automatic test_boundary();
        pix_t s[$];
        pix_t fs = idle_pix();
        pix_t fs_ov;
        fs.fs = 1'b1;
        fs_ov = lay(lay(fs, 1, 12'h321), 2, 12'h654);
        s.push_back(fs);
        for (int k = 0; k < 4; k++) s.push_back(idle_pix());
        s.push_back(fs_ov);
        for (int k = 0; k < 4; k++) s.push_back(idle_pix());
        s.push_back(fs);
        run_frames("boundary", s, 5, 15'h0000, 10, 15'h0020);
    endtask

    task automatic test_reset_midframe();
        pix_t s[$];
        pix_t fs = idle_pix();
        pix_t ov = lay(lay(idle_pix(), 0, 12'h111), 1, 12'h222);
        fs.fs = 1'b1;
        step(fs);
        for (int k = 0; k < 4; k++) step(ov);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_chk++; if (bus.rgb_out !== 12'h000) $display("FAIL midrst_rgb: got %h want 000", bus.rgb_out); else n_pass++;
        n_chk++; if (bus.rgb_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", bus.rgb_valid); else n_pass++;
        n_chk++; if (bus.hit_layer !== 3'd6) $display("FAIL midrst_hit: got %0d want 6", bus.hit_layer); else n_pass++;
        n_chk++; if (bus.coll_flags !== 15'h0) $display("FAIL midrst_flags: got %h want 0", bus.coll_flags); else n_pass++;
        release_reset();
        for (int k = 0; k < 5; k++) s.push_back(idle_pix());
        s.push_back(fs);
        s.push_back(idle_pix());
        s.push_back(fs);
        run_frames("post_reset", s, 5, 15'h0000, 7, 15'h0000);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_acc = '0;
        m_flags = '0;
        test_reset();
        test_priority();
        test_key_mask();
        test_modes();
        test_random();
        test_collision();
        test_boundary();
        test_random();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
